// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// held output word with valid/ready acceptance and overrun reporting.
module uart_rx_ovs #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_data,
  input  logic                 dout_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 en,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic PAR_ON    = (PARITY_EN != 0);
  localparam logic ODD       = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        timer;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc, pe_acc;
  logic                 timer_clr, sample_data, sample_par, sample_stop;
  logic                 done, fe_done, pe_calc;

  assign state_dbg = state;
  assign fe_done   = fe_acc | ~rx_s;
  assign pe_calc   = (^shreg) ^ rx_s ^ ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
      state   <= state_next;
    end
  end

  // Every sampling step clears the timer, so it never wraps inside a bit.
  always_comb begin
    state_next  = state;
    timer_clr   = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    sample_stop = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          timer_clr  = 1'b1;
        end
      end
      START: begin
        if (timer == T_MID) begin
          timer_clr  = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == T_LAST) begin
          timer_clr   = 1'b1;
          sample_data = 1'b1;
          if (bit_cnt == B_LAST) state_next = PAR_ON ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (timer == T_LAST) begin
          timer_clr  = 1'b1;
          sample_par = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (timer == T_LAST) begin
          timer_clr   = 1'b1;
          sample_stop = 1'b1;
          if (stop_cnt == STOP_LAST) begin
            done       = 1'b1;
            state_next = fe_done ? WAIT_HIGH : IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      fe_acc   <= 1'b0;
      pe_acc   <= 1'b0;
    end else begin
      if (timer_clr) timer <= '0;
      else if (state != IDLE && state != WAIT_HIGH) timer <= timer + 1'b1;

      if (sample_data) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
      end else if (state != DATA) begin
        bit_cnt <= '0;
      end

      if (sample_stop) stop_cnt <= ~stop_cnt;
      else if (state != STOP) stop_cnt <= 1'b0;

      if (state == START) begin
        fe_acc <= 1'b0;
        pe_acc <= 1'b0;
      end else begin
        if (sample_stop && !rx_s) fe_acc <= 1'b1;
        if (sample_par) pe_acc <= pe_calc;
      end
    end
  end

  // A completing frame loads only if the held word is empty or leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      en         <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!en || dout_ready) begin
          dout       <= shreg;
          frame_err  <= fe_done;
          parity_err <= pe_acc;
          en         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (en && dout_ready) begin
        en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: a default-configured instance and an
// even-parity, two-stop-bit instance driven with hand-built serial frames.
module tb_uart_rx_ovs;

  localparam int CPB = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, ready0, ready1;
  logic [7:0] dout0, dout1;
  logic       en0, en1, fe0, fe1, pe0, pe1, ovr0, ovr1;
  logic [2:0] st0, st1;

  int n_tests = 0;
  int n_fail  = 0;

  int         rises0 = 0, rises1 = 0, ovr_cnt0 = 0;
  logic       en0_q = 1'b0, en1_q = 1'b0;
  logic [7:0] cap_dout0, cap_dout1;
  logic       cap_fe0, cap_pe0, cap_fe1, cap_pe1;

  always #5 clk = ~clk;

  uart_rx_ovs dut0 (
    .clk(clk), .rst(rst), .rx_data(rx0), .dout_ready(ready0),
    .dout(dout0), .en(en0), .frame_err(fe0), .parity_err(pe0),
    .overrun(ovr0), .state_dbg(st0)
  );

  uart_rx_ovs #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx1), .dout_ready(ready1),
    .dout(dout1), .en(en1), .frame_err(fe1), .parity_err(pe1),
    .overrun(ovr1), .state_dbg(st1)
  );

  // Count each new word presentation and capture it with its flags.
  always @(negedge clk) begin
    if (en0 && !en0_q) begin
      rises0++;
      cap_dout0 = dout0; cap_fe0 = fe0; cap_pe0 = pe0;
    end
    if (ovr0) ovr_cnt0++;
    en0_q = en0;
    if (en1 && !en1_q) begin
      rises1++;
      cap_dout1 = dout1; cap_fe1 = fe1; cap_pe1 = pe1;
    end
    en1_q = en1;
  end

  task automatic drive_bit(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit use_par,
                      input logic par_bit, input int nstop, input logic stop_val);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_val);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", en0); end
    n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout0); end
    n_tests++; if ({fe0, pe0, ovr0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {fe0, pe0, ovr0}); end
    n_tests++; if (st0 !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", st0); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int r;
    r = rises0;
    send(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (rises0 - r !== 1) begin n_fail++; $display("FAIL a5_en_count got %0d want 1", rises0 - r); end
    n_tests++; if (cap_dout0 !== 8'hA5) begin n_fail++; $display("FAIL a5_dout got %h want a5", cap_dout0); end
    n_tests++; if ({cap_fe0, cap_pe0} !== 2'b00) begin n_fail++; $display("FAIL a5_flags got %b want 00", {cap_fe0, cap_pe0}); end
    n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL a5_en_single got %b want 0", en0); end
  endtask

  task automatic test_glitch;
    int r;
    r = rises0;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    n_tests++; if (rises0 !== r) begin n_fail++; $display("FAIL glitch_en got %0d want %0d", rises0, r); end
    n_tests++; if (st0 !== S_IDLE) begin n_fail++; $display("FAIL glitch_state got %0d want 0", st0); end
    send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (rises0 - r !== 1) begin n_fail++; $display("FAIL glitch_next_count got %0d want 1", rises0 - r); end
    n_tests++; if (cap_dout0 !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_dout got %h want 3c", cap_dout0); end
  endtask

  task automatic test_parity;
    // 0x07 has three ones, so even parity needs parity bit 1.
    send(1, 8'h07, 1'b1, 1'b0, 2, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (cap_dout1 !== 8'h07) begin n_fail++; $display("FAIL par_bad_dout got %h want 07", cap_dout1); end
    n_tests++; if (cap_pe1 !== 1'b1) begin n_fail++; $display("FAIL par_bad_pe got %b want 1", cap_pe1); end
    n_tests++; if (cap_fe1 !== 1'b0) begin n_fail++; $display("FAIL par_bad_fe got %b want 0", cap_fe1); end
    send(1, 8'h07, 1'b1, 1'b1, 2, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (rises1 !== 2) begin n_fail++; $display("FAIL par_count got %0d want 2", rises1); end
    n_tests++; if (cap_pe1 !== 1'b0) begin n_fail++; $display("FAIL par_good_pe got %b want 0", cap_pe1); end
  endtask

  task automatic test_frame_err;
    int r;
    r = rises0;
    send(0, 8'h55, 1'b0, 1'b0, 1, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    n_tests++; if (rises0 - r !== 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", rises0 - r); end
    n_tests++; if (cap_fe0 !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", cap_fe0); end
    n_tests++; if (cap_dout0 !== 8'h55) begin n_fail++; $display("FAIL ferr_dout got %h want 55", cap_dout0); end
    n_tests++; if (st0 !== S_WAIT) begin n_fail++; $display("FAIL ferr_hold_state got %0d want 5", st0); end
    rx0 = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++; if (st0 !== S_IDLE) begin n_fail++; $display("FAIL ferr_release_state got %0d want 0", st0); end
  endtask

  task automatic test_overrun;
    int r, o;
    r = rises0; o = ovr_cnt0;
    ready0 = 1'b0;
    send(0, 8'h11, 1'b0, 1'b0, 1, 1'b1);
    send(0, 8'h22, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (dout0 !== 8'h11) begin n_fail++; $display("FAIL ovr_held_dout got %h want 11", dout0); end
    n_tests++; if (en0 !== 1'b1) begin n_fail++; $display("FAIL ovr_held_en got %b want 1", en0); end
    n_tests++; if (ovr_cnt0 - o !== 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt0 - o); end
    n_tests++; if (rises0 - r !== 1) begin n_fail++; $display("FAIL ovr_en_count got %0d want 1", rises0 - r); end
    ready0 = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_en got %b want 0", en0); end
    n_tests++; if (dout0 !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_dout got %h want 11", dout0); end
  endtask

  task automatic test_back_to_back;
    int r;
    r = rises0;
    send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b1);
    send(0, 8'hC3, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (rises0 - r !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", rises0 - r); end
    n_tests++; if (cap_dout0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_dout got %h want c3", cap_dout0); end
  endtask

  task automatic test_reset_mid_frame;
    int r;
    logic [7:0] d;
    r = rises0;
    d = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rst = 1'b1; rx0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    n_tests++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_en got %b want 0", en0); end
    n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL rstmid_dout got %h want 00", dout0); end
    n_tests++; if ({fe0, pe0} !== 2'b00) begin n_fail++; $display("FAIL rstmid_flags got %b want 00", {fe0, pe0}); end
    n_tests++; if (rises0 !== r) begin n_fail++; $display("FAIL rstmid_no_en got %0d want %0d", rises0, r); end
    n_tests++; if (st0 !== S_IDLE) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", st0); end
    send(0, 8'h81, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++; if (rises0 - r !== 1) begin n_fail++; $display("FAIL rstmid_next_count got %0d want 1", rises0 - r); end
    n_tests++; if (cap_dout0 !== 8'h81) begin n_fail++; $display("FAIL rstmid_next_dout got %h want 81", cap_dout0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16; clocks per bit period; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8; data bits per frame; range 5..8.
REQ-003 Parameter PARITY_EN, default 0; 1 = one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1; stop bits checked per frame; 1 or 2.
REQ-006 clk  input  1  single clock; all logic on the rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 rx_data  input  1  asynchronous serial line; idles high.
REQ-009 dout_ready  input  1  consumer accepts the held word when high together with en.
REQ-010 dout  output  DATA_BITS  received word, LSB first on the line.
REQ-011 en  output  1  dout and its error flags are valid; held until accepted.
REQ-012 frame_err  output  1  a stop bit sampled low; valid with en.
REQ-013 parity_err  output  1  parity mismatch; valid with en; always 0 when PARITY_EN=0.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx_data SHALL pass through a two-flop synchroniser; all decisions use the synchronised value (rx_s).
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE: a low rx_s moves to START and clears the bit-timer.
REQ-018 START: at timer = CLKS_PER_BIT/2-1 (mid-bit), rx_s low moves to DATA and restarts the timer; rx_s high returns to IDLE (glitch reject, no flags, no en).
REQ-019 DATA: sample rx_s every CLKS_PER_BIT clocks at mid-bit into bit index 0..DATA_BITS-1 (LSB first); after the last bit, go to PARITY if PARITY_EN=1, else STOP.
REQ-020 PARITY: sample one bit; parity_err_next = (XOR of data bits XOR sampled bit) != PARITY_ODD.
REQ-021 STOP: sample STOP_BITS bits; any low sample sets frame_err_next.
REQ-022 After the last stop sample, the frame SHALL complete: if no error, go to IDLE; if frame_err_next, go to WAIT_HIGH.
REQ-023 WAIT_HIGH: stay until rx_s is high (break/line-low protection), then go to IDLE.
REQ-024 Frame completion SHALL load dout, frame_err and parity_err and set en on the next clock edge (1-cycle latency from the final stop mid-sample).
REQ-025 en SHALL stay high and dout/flags stable until a cycle with en=1 and dout_ready=1; en clears on the following edge.
REQ-026 Frame completes while en=1 and dout_ready=0: the new frame is discarded, the held word is unchanged, and overrun pulses for 1 cycle.
REQ-027 Frame completes in the same cycle as a handshake (en=1, dout_ready=1): the new word loads, en stays high, no overrun.
REQ-028 The receiver SHALL keep receiving regardless of en; back-to-back frames with no idle gap are supported.
REQ-029 Bit-timer width SHALL be clog2(CLKS_PER_BIT); bit counter width clog2(DATA_BITS+1); neither wraps mid-bit.

Reset
REQ-030 With rst high at a clock edge: state=IDLE, timers=0, synchroniser flops=1, dout=0, en=0, frame_err=0, parity_err=0, overrun=0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no en and no flags; reception restarts on the next falling edge after rst deasserts.

Verification
REQ-032 Defaults, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit, dout_ready=1 -> en high 1 cycle, dout=0xA5, both error flags 0.
REQ-033 rx_data low for 4 clocks in IDLE -> no en; FSM back in IDLE; a following valid 0x3C frame is received correctly.
REQ-034 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> en with dout=0x07, parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-035 Send 0x55 with stop bit low, then hold the line low for 40 bit-times -> en with frame_err=1, exactly one en, FSM held in WAIT_HIGH until the line is high.
REQ-036 dout_ready=0, send 0x11 then 0x22 back-to-back -> dout=0x11 held, overrun pulses once at the second completion; then dout_ready=1 -> en clears, dout stays 0x11.
REQ-037 Assert rst after the 4th data bit of a frame -> all outputs 0, no en; the next full 0x81 frame is received correctly.
